// File: rtl/mem_access_sequencer_pkg.sv
// Shared encodings for the fetch/data memory sequencer: funct3 size codes,
// NOP encoding, phase values and small decode helpers.
package mem_access_sequencer_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP_ENC = 32'h0000_0013;

  localparam logic [0:0] PHASE_FETCH = 1'b0;
  localparam logic [0:0] PHASE_DATA  = 1'b1;

  function automatic logic f3_legal(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Access size in bytes; illegal codes report 4 but are faulted anyway.
  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Unified byte-memory port: the sequencer drives address/controls, memory returns read data.
interface mem_access_sequencer_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic        mem_half;
  logic        mem_byte;

  modport master (
    output mem_addr, mem_wdata, mem_read, mem_write, mem_half, mem_byte,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_read, mem_write, mem_half, mem_byte,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_sequencer_load_ext.sv
// Load result extension: picks byte/half/word from the raw memory word and
// sign- or zero-extends it according to funct3.
module load_ext_unit
  import mem_access_sequencer_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{rdata[7]}}, rdata[7:0]};
      F3_BU:   data = {24'b0, rdata[7:0]};
      F3_H:    data = {{16{rdata[15]}}, rdata[15:0]};
      F3_HU:   data = {16'b0, rdata[15:0]};
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/mem_access_sequencer.sv
// Time-multiplexes one unified byte memory between instruction fetch (phase 0)
// and load/store (phase 1); latches the IF/ID word and the extended load result.
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] NOP_INSN = NOP_ENC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic        stall,
  input  logic        flush,
  mem_access_sequencer_if.master bus,
  output logic        tick_tock,
  output logic        stage_en,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_fault
);

  logic [0:0]  phase;
  logic        data_ph, acc, both, illegal, misalign, oob, fault;
  logic [2:0]  size;
  logic [32:0] mem_span;
  logic [31:0] ext_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= PHASE_FETCH;
    else        phase <= ~phase;
  end

  assign data_ph   = (phase == PHASE_DATA);
  assign tick_tock = phase[0];
  assign stage_en  = phase[0];

  assign acc      = data_ph & (ex_mem_read | ex_mem_write);
  assign size     = f3_size(ex_funct3);
  assign both     = ex_mem_read & ex_mem_write;
  assign illegal  = ~f3_legal(ex_funct3);
  assign misalign = ((size == 3'd2) & ex_addr[0]) | ((size == 3'd4) & (|ex_addr[1:0]));
  // 33-bit compare so a full 32-bit address space still has a representable span.
  assign mem_span = 33'(1) << ADDR_W;
  assign oob      = {1'b0, ex_addr} > (mem_span - {30'b0, size});
  assign fault    = acc & (both | illegal | misalign | oob);

  assign bus.mem_addr  = data_ph ? ex_addr : pc;
  assign bus.mem_wdata = ex_wdata;
  assign bus.mem_read  = acc & ex_mem_read  & ~fault;
  assign bus.mem_write = acc & ex_mem_write & ~fault;
  assign bus.mem_half  = acc & (ex_funct3[1:0] == 2'b01);
  assign bus.mem_byte  = acc & (ex_funct3[1:0] == 2'b00);

  load_ext_unit u_ext (
    .funct3 (ex_funct3),
    .rdata  (bus.mem_rdata),
    .data   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr        <= NOP_INSN;
      instr_valid  <= 1'b0;
      load_data    <= '0;
      load_valid   <= 1'b0;
      access_fault <= 1'b0;
    end else begin
      // mem_read is already zero outside D, so these pulse only after a data phase.
      load_valid   <= bus.mem_read;
      access_fault <= fault;
      if (bus.mem_read) load_data <= ext_data;
      if (!data_ph) begin
        if (flush) begin
          instr       <= NOP_INSN;
          instr_valid <= 1'b0;
        end else if (!stall) begin
          instr       <= bus.mem_rdata;
          instr_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: byte-array memory plus a slot-level reference model.
module tb_mem_access_sequencer;
  import mem_access_sequencer_pkg::*;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc, ex_addr, ex_wdata;
  logic        ex_mem_read, ex_mem_write, stall, flush;
  logic [2:0]  ex_funct3;
  logic        tick_tock, stage_en, instr_valid, load_valid, access_fault;
  logic [31:0] instr, load_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_sequencer_if bus();

  mem_access_sequencer #(.ADDR_W(8), .NOP_INSN(32'h0000_0013)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc           (pc),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_funct3    (ex_funct3),
    .stall        (stall),
    .flush        (flush),
    .bus          (bus),
    .tick_tock    (tick_tock),
    .stage_en     (stage_en),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .access_fault (access_fault)
  );

  // Memory under the DUT (little-endian, wraps at DEPTH) and the model's image of it.
  logic [7:0] mem     [DEPTH];
  logic [7:0] ref_mem [DEPTH];
  logic       load_img = 1'b0;
  logic [7:0] a0, a1, a2, a3;

  assign a0 = bus.mem_addr[7:0];
  assign a1 = a0 + 8'd1;
  assign a2 = a0 + 8'd2;
  assign a3 = a0 + 8'd3;
  assign bus.mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};

  always @(posedge clk) begin
    if (load_img) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
    end else if (bus.mem_write) begin
      mem[a0] <= bus.mem_wdata[7:0];
      if (!bus.mem_byte) mem[a1] <= bus.mem_wdata[15:8];
      if (!bus.mem_byte && !bus.mem_half) begin
        mem[a2] <= bus.mem_wdata[23:16];
        mem[a3] <= bus.mem_wdata[31:24];
      end
    end
  end

  // Reference state
  logic [31:0] m_instr, m_ld;
  logic        m_valid, m_lv, m_af;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a[7:0]);
    return {ref_mem[(b+3)%DEPTH], ref_mem[(b+2)%DEPTH], ref_mem[(b+1)%DEPTH], ref_mem[b]};
  endfunction

  task automatic chk_mem(input string tag);
    int nd = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) nd++;
    chk(tag, 32'(nd), 32'd0);
  endtask

  task automatic model_reset();
    m_instr = 32'h0000_0013; m_valid = 1'b0;
    m_ld = '0; m_lv = 1'b0; m_af = 1'b0;
  endtask

  // One instruction slot: F cycle then D cycle. Entered just after the D->F edge.
  task automatic slot(input logic [31:0] pc_i, input logic st, input logic fl,
                      input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd);
    logic acc, ill, flt;
    int   sz;
    logic [31:0] v;
    pc = pc_i; stall = st; flush = fl;
    ex_mem_read = rd; ex_mem_write = wr; ex_funct3 = f3; ex_addr = addr; ex_wdata = wd;

    @(negedge clk);
    chk("f_phase", {31'b0, tick_tock}, 32'd0);
    chk("f_addr", bus.mem_addr, pc_i);
    chk("f_ctrl", {28'b0, bus.mem_read, bus.mem_write, bus.mem_half, bus.mem_byte}, 32'd0);
    chk("f_lvalid", {31'b0, load_valid}, {31'b0, m_lv});
    chk("f_fault", {31'b0, access_fault}, {31'b0, m_af});
    chk("f_ldata", load_data, m_ld);

    if (fl) begin m_instr = 32'h0000_0013; m_valid = 1'b0; end
    else if (!st) begin m_instr = ref_word(pc_i); m_valid = 1'b1; end

    @(posedge clk); #1;
    chk("instr", instr, m_instr);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    chk("d_phase", {30'b0, tick_tock, stage_en}, 32'd3);
    chk("d_lvalid", {31'b0, load_valid}, 32'd0);
    chk("d_addr", bus.mem_addr, addr);
    chk("wdata", bus.mem_wdata, wd);

    acc = rd | wr;
    ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    flt = acc && ((rd && wr) || ill || (addr % sz != 0) ||
                  (longint'(addr) > longint'(DEPTH - sz)));
    chk("d_ctrl", {28'b0, bus.mem_read, bus.mem_write, bus.mem_half, bus.mem_byte},
        {28'b0, rd && !flt, wr && !flt, acc && !ill && sz == 2, acc && !ill && sz == 1});

    m_af = flt;
    m_lv = rd && !flt;
    if (m_lv) begin
      v = ref_word(addr);
      case (f3)
        3'd0:    m_ld = (v[7:0] >= 8'd128) ? 32'(int'(v[7:0]) - 256) : {24'b0, v[7:0]};
        3'd4:    m_ld = {24'b0, v[7:0]};
        3'd1:    m_ld = (v[15:0] >= 16'd32768) ? 32'(int'(v[15:0]) - 65536) : {16'b0, v[15:0]};
        3'd5:    m_ld = {16'b0, v[15:0]};
        default: m_ld = v;
      endcase
    end
    if (wr && !flt)
      for (int k = 0; k < sz; k++) ref_mem[int'(addr) + k] = wd[8*k +: 8];

    @(posedge clk); #1;
    chk("load_valid", {31'b0, load_valid}, {31'b0, m_lv});
    chk("access_fault", {31'b0, access_fault}, {31'b0, m_af});
    chk("load_data", load_data, m_ld);
    chk_mem("mem");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_phase"}, {31'b0, tick_tock}, 32'd0);
    chk({tag, "_wr"}, {31'b0, bus.mem_write}, 32'd0);
    chk({tag, "_instr"}, instr, 32'h0000_0013);
    chk({tag, "_flags"}, {29'b0, instr_valid, load_valid, access_fault}, 32'd0);
    chk({tag, "_ldata"}, load_data, 32'd0);
  endtask

  initial begin
    logic [2:0] legal_f3 [5];
    logic [2:0] f3r;
    logic [31:0] ar;
    int op;
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    pc = '0; ex_addr = '0; ex_wdata = '0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_funct3 = '0; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'($urandom);
    ref_mem[0] = 8'h13; ref_mem[1] = 8'h00; ref_mem[2] = 8'h00; ref_mem[3] = 8'h00;
    ref_mem[8] = 8'hF4;

    load_img = 1'b1;
    repeat (2) @(posedge clk);
    #1 load_img = 1'b0;
    model_reset();
    chk_reset_outputs("reset");
    chk_mem("img");
    rst_n = 1'b1;

    // Fetch of NOP at 0
    slot(32'd0, 0, 0, 0, 0, F3_B, 32'd0, 32'd0);
    chk("nop_fetch", instr, 32'h0000_0013);
    // Signed and unsigned byte load of 0xF4
    slot(32'd4, 0, 0, 1, 0, F3_B, 32'd8, 32'd0);
    chk("lb_f4", load_data, 32'hFFFF_FFF4);
    slot(32'd4, 0, 0, 1, 0, F3_BU, 32'd8, 32'd0);
    chk("lbu_f4", load_data, 32'h0000_00F4);
    // Halfword store at 6
    slot(32'd8, 0, 0, 0, 1, F3_H, 32'd6, 32'hAAAA_1234);
    chk("sh_b6_b7_b8", {8'b0, mem[8], mem[7], mem[6]}, 32'h00F4_1234);
    // Faults: misaligned word, read+write, out of range, illegal funct3
    slot(32'd12, 0, 0, 1, 0, F3_W, 32'd5, 32'd0);
    chk("fault_keeps_ld", load_data, 32'h0000_00F4);
    slot(32'd12, 0, 0, 1, 1, F3_W, 32'd4, 32'd0);
    slot(32'd12, 0, 0, 1, 0, F3_H, 32'd255, 32'd0);
    slot(32'd12, 0, 0, 1, 0, F3_W, 32'd252, 32'd0);
    slot(32'd12, 0, 0, 0, 1, F3_B, 32'd256, 32'h55);
    slot(32'd12, 0, 0, 1, 0, 3'b011, 32'd0, 32'd0);
    slot(32'd12, 0, 0, 0, 1, F3_HU, 32'd254, 32'h0000_BEEF);
    // Flush beats stall; stall holds for two slots
    slot(32'd16, 1, 1, 0, 0, F3_B, 32'd0, 32'd0);
    slot(32'd0,  0, 0, 0, 0, F3_B, 32'd0, 32'd0);
    slot(32'd20, 1, 0, 0, 0, F3_B, 32'd0, 32'd0);
    slot(32'd24, 1, 0, 0, 0, F3_B, 32'd0, 32'd0);
    chk("stall_hold", instr, 32'h0000_0013);

    for (int n = 0; n < 300; n++) begin
      op  = int'($urandom_range(0, 5));
      f3r = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
      case ($urandom_range(0, 15))
        0:       ar = $urandom;
        1, 2:    ar = 32'($urandom_range(248, 270));
        default: ar = 32'($urandom_range(0, 255));
      endcase
      slot({24'b0, 6'($urandom), 2'b00}, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
           op inside {1, 2, 5}, op inside {3, 4, 5}, f3r, ar, $urandom);
    end

    // Reset during a word store in D
    pc = 32'd0; stall = 1'b0; flush = 1'b0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b1; ex_funct3 = F3_W;
    ex_addr = 32'd0; ex_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("pre_rst_wr", {31'b0, bus.mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    chk_mem("midrst_mem");
    chk_reset_outputs("midrst_hold");
    model_reset();
    rst_n = 1'b1;
    slot(32'd0, 0, 0, 1, 0, F3_W, 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
